// File: rtl/ysyx_24110015_axil_sram_if.sv
// AXI4-Lite bundle shared by the SRAM slave and its master.
// Only the fields the SRAM uses are carried; arsize/awsize are passed through for completeness.
interface axi_lite_if;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arsize, arvalid, rready,
        output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arsize, arvalid, rready,
        input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_24110015_axil_sram.sv
// AXI4-Lite SRAM slave: independent read and write FSMs over one word array,
// programmable response latency, byte-lane writes, SLVERR outside the window.
//
// state  | meaning
// R_IDLE | arready high, waiting for an address
// R_WAIT | latency down-counter running, data captured when it hits zero
// R_RESP | rvalid high until rready
// W_IDLE | collecting AW and W (either order), each captured once
// W_WAIT | latency down-counter running, write commits when it hits zero
// W_RESP | bvalid high until bready
module ysyx_24110015_axil_sram #(
    parameter logic [31:0] BASE_ADDR = 32'h0f000000,
    parameter int          MEM_WORDS = 1024,
    parameter int          READ_LAT  = 1,
    parameter int          WRITE_LAT = 1
) (
    input  logic      clk,
    input  logic      rst,
    axi_lite_if.slave axiif
);
    localparam int          IDX_W = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN  = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [31:0] r_mem [MEM_WORDS];

    r_state_t    r_rstate, w_rnext;
    logic [3:0]  r_rcnt;
    logic [31:0] r_araddr;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        w_ar_hs, w_r_cap;

    w_state_t    r_wstate, w_wnext;
    logic [3:0]  r_wcnt;
    logic        r_aw_cap, r_w_cap;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp;
    logic        w_aw_hs, w_w_hs, w_commit, w_b_done;

    logic [31:0]      w_ar_off, w_aw_off;
    logic             w_ar_ok, w_aw_ok;
    logic [IDX_W-1:0] w_ar_idx, w_aw_idx;
    logic             w_unused_size;

    // Subtracting first makes addresses below the base wrap to huge offsets,
    // so one unsigned compare covers both ends of the window.
    assign w_ar_off = r_araddr - BASE_ADDR;
    assign w_aw_off = r_awaddr - BASE_ADDR;
    assign w_ar_ok  = w_ar_off < SPAN;
    assign w_aw_ok  = w_aw_off < SPAN;
    assign w_ar_idx = w_ar_off[IDX_W+1:2];
    assign w_aw_idx = w_aw_off[IDX_W+1:2];
    assign w_unused_size = ^{axiif.arsize, axiif.awsize};

    always_comb begin
        w_rnext = r_rstate;
        w_ar_hs = 1'b0;
        w_r_cap = 1'b0;
        case (r_rstate)
            R_IDLE: if (axiif.arvalid) begin
                w_ar_hs = 1'b1;
                w_rnext = R_WAIT;
            end
            R_WAIT: if (r_rcnt == 4'd0) begin
                w_r_cap = 1'b1;
                w_rnext = R_RESP;
            end
            R_RESP: if (axiif.rready) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate <= R_IDLE;
            r_rcnt   <= 4'd0;
            r_araddr <= 32'd0;
            r_rdata  <= 32'd0;
            r_rresp  <= 2'b00;
        end else begin
            r_rstate <= w_rnext;
            if (w_ar_hs) begin
                r_araddr <= axiif.araddr;
                r_rcnt   <= 4'(READ_LAT - 1);
            end else if (r_rstate == R_WAIT && r_rcnt != 4'd0) begin
                r_rcnt <= r_rcnt - 4'd1;
            end
            // Array read here sees pre-write data if a commit lands on the same edge.
            if (w_r_cap) begin
                r_rdata <= w_ar_ok ? r_mem[w_ar_idx] : 32'd0;
                r_rresp <= w_ar_ok ? 2'b00 : 2'b10;
            end
        end
    end

    always_comb begin
        w_wnext  = r_wstate;
        w_aw_hs  = 1'b0;
        w_w_hs   = 1'b0;
        w_commit = 1'b0;
        w_b_done = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_aw_hs = axiif.awvalid && !r_aw_cap;
                w_w_hs  = axiif.wvalid && !r_w_cap;
                if (r_aw_cap && r_w_cap) w_wnext = W_WAIT;
            end
            W_WAIT: if (r_wcnt == 4'd0) begin
                w_commit = 1'b1;
                w_wnext  = W_RESP;
            end
            W_RESP: if (axiif.bready) begin
                w_b_done = 1'b1;
                w_wnext  = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate <= W_IDLE;
            r_wcnt   <= 4'd0;
            r_aw_cap <= 1'b0;
            r_w_cap  <= 1'b0;
            r_awaddr <= 32'd0;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
            r_bresp  <= 2'b00;
        end else begin
            r_wstate <= w_wnext;
            if (w_aw_hs) begin
                r_aw_cap <= 1'b1;
                r_awaddr <= axiif.awaddr;
            end
            if (w_w_hs) begin
                r_w_cap <= 1'b1;
                r_wdata <= axiif.wdata;
                r_wstrb <= axiif.wstrb;
            end
            if (r_wstate == W_IDLE && w_wnext == W_WAIT) begin
                r_wcnt <= 4'(WRITE_LAT - 1);
            end else if (r_wstate == W_WAIT && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            if (w_commit) r_bresp <= w_aw_ok ? 2'b00 : 2'b10;
            if (w_b_done) begin
                r_aw_cap <= 1'b0;
                r_w_cap  <= 1'b0;
            end
        end
    end

    // No reset on the array; commit is gated by the reset-cleared write FSM.
    always_ff @(posedge clk) begin
        if (w_commit && w_aw_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wstrb[i]) r_mem[w_aw_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign axiif.arready = rst && (r_rstate == R_IDLE);
    assign axiif.rvalid  = (r_rstate == R_RESP);
    assign axiif.rdata   = r_rdata;
    assign axiif.rresp   = r_rresp;
    assign axiif.awready = rst && (r_wstate == W_IDLE) && !r_aw_cap;
    assign axiif.wready  = rst && (r_wstate == W_IDLE) && !r_w_cap;
    assign axiif.bvalid  = (r_wstate == W_RESP);
    assign axiif.bresp   = r_bresp;
endmodule

// File: tb/tb_ysyx_24110015_axil_sram.sv
// Directed plus randomized bench for the AXI-Lite SRAM, checked against a
// byte-addressed memory model with window-based error responses.
module tb_ysyx_24110015_axil_sram;
    localparam logic [31:0] BASE  = 32'h0f000000;
    localparam int          WORDS = 1024;
    localparam int          RLAT  = 3;
    localparam int          WLAT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    axi_lite_if axiif();

    ysyx_24110015_axil_sram #(
        .BASE_ADDR(BASE), .MEM_WORDS(WORDS), .READ_LAT(RLAT), .WRITE_LAT(WLAT)
    ) dut (
        .clk(clk), .rst(rst), .axiif(axiif)
    );

    always #5 clk = ~clk;

    logic [7:0] bmem [longint];

    function automatic bit in_win(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * WORDS);
    endfunction

    function automatic bit known(input logic [31:0] a);
        longint b = longint'({a[31:2], 2'b00});
        return bmem.exists(b) && bmem.exists(b+1) && bmem.exists(b+2) && bmem.exists(b+3);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        longint b = longint'({a[31:2], 2'b00});
        return {bmem[b+3], bmem[b+2], bmem[b+1], bmem[b]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        chk({tag, "_arready"}, 32'(axiif.arready), 0);
        chk({tag, "_awready"}, 32'(axiif.awready), 0);
        chk({tag, "_wready"},  32'(axiif.wready), 0);
        chk({tag, "_rvalid"},  32'(axiif.rvalid), 0);
        chk({tag, "_bvalid"},  32'(axiif.bvalid), 0);
        chk({tag, "_rdata"},   axiif.rdata, 0);
        chk({tag, "_rresp"},   32'(axiif.rresp), 0);
        chk({tag, "_bresp"},   32'(axiif.bresp), 0);
    endtask

    // mode 0: AW+W together, 1: W one cycle before AW, 2: AW one cycle before W
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int mode, input int bhold);
        bit aw_todo = 1, w_todo = 1, hs_aw, hs_w;
        int i = 0, n = 0;
        logic [1:0] exp_b = in_win(a) ? 2'b00 : 2'b10;
        logic [1:0] held;
        while ((aw_todo || w_todo) && i < 20) begin
            @(negedge clk);
            axiif.awaddr  = a;
            axiif.wdata   = d;
            axiif.wstrb   = s;
            axiif.awvalid = aw_todo && !(mode == 1 && i == 0);
            axiif.wvalid  = w_todo && !(mode == 2 && i == 0);
            hs_aw = axiif.awvalid && axiif.awready;
            hs_w  = axiif.wvalid && axiif.wready;
            @(posedge clk);
            if (hs_aw) aw_todo = 0;
            if (hs_w) w_todo = 0;
            i++;
        end
        @(negedge clk);
        axiif.awvalid = 1'b0;
        axiif.wvalid  = 1'b0;
        chk("wr_accept", 32'({aw_todo, w_todo}), 0);
        while (!axiif.bvalid && n < 40) begin
            @(posedge clk); @(negedge clk); n++;
        end
        chk("wr_bvalid", 32'(axiif.bvalid), 1);
        held = axiif.bresp;
        for (int h = 0; h < bhold; h++) begin
            chk("bhold_bvalid", 32'(axiif.bvalid), 1);
            chk("bhold_awready", 32'(axiif.awready), 0);
            chk("bhold_wready", 32'(axiif.wready), 0);
            chk("bhold_bresp", 32'(axiif.bresp), 32'(held));
            @(posedge clk); @(negedge clk);
        end
        chk("wr_bresp", 32'(axiif.bresp), 32'(exp_b));
        axiif.bready = 1'b1;
        @(posedge clk); @(negedge clk);
        axiif.bready = 1'b0;
        chk("wr_bdone", 32'(axiif.bvalid), 0);
        if (in_win(a)) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) bmem[longint'({a[31:2], 2'b00}) + k] = d[8*k +: 8];
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int rhold);
        int lat = 0;
        logic [31:0] held;
        @(negedge clk);
        chk("rd_arready", 32'(axiif.arready), 1);
        axiif.araddr  = a;
        axiif.arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        axiif.arvalid = 1'b0;
        while (!axiif.rvalid && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        chk("rd_latency", lat, RLAT);
        if (!in_win(a)) begin
            chk("rd_oor_data", axiif.rdata, 0);
            chk("rd_oor_resp", 32'(axiif.rresp), 2);
        end else begin
            if (known(a)) chk("rd_data", axiif.rdata, model_word(a));
            chk("rd_resp", 32'(axiif.rresp), 0);
        end
        held = axiif.rdata;
        for (int h = 0; h < rhold; h++) begin
            @(posedge clk); @(negedge clk);
            chk("rhold_rvalid", 32'(axiif.rvalid), 1);
            chk("rhold_rdata", axiif.rdata, held);
            chk("rhold_arready", 32'(axiif.arready), 0);
        end
        axiif.rready = 1'b1;
        @(posedge clk); @(negedge clk);
        axiif.rready = 1'b0;
        chk("rd_done", 32'(axiif.rvalid), 0);
    endtask

    initial begin
        logic [31:0] a, d;
        int n;
        axiif.araddr = '0; axiif.arsize = 3'd2; axiif.arvalid = 1'b0; axiif.rready = 1'b0;
        axiif.awaddr = '0; axiif.awsize = 3'd2; axiif.awvalid = 1'b0;
        axiif.wdata = '0; axiif.wstrb = '0; axiif.wvalid = 1'b0; axiif.bready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet_outputs("reset");
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_arready", 32'(axiif.arready), 1);
        chk("post_rst_awready", 32'(axiif.awready), 1);
        chk("post_rst_wready", 32'(axiif.wready), 1);

        do_write(32'h0f000010, 32'hdeadbeef, 4'hf, 0, 0);
        do_read(32'h0f000010, 0);

        do_write(32'h0f000010, 32'h11223344, 4'hf, 0, 0);
        do_write(32'h0f000010, 32'h000000aa, 4'b0001, 2, 0);
        do_write(32'h0f000010, 32'h55000000, 4'b1000, 0, 0);
        do_read(32'h0f000012, 0);
        @(negedge clk);
        chk("merge_value", axiif.rdata, 32'h552233aa);

        do_write(32'h0f000020, 32'h01020304, 4'hf, 1, 0);
        do_write(32'h0f000024, 32'ha5a5a5a5, 4'hf, 0, 0);
        do_read(32'h0f000020, 0);
        do_read(32'h0f000024, 0);

        do_write(32'h0f000010, 32'h99999999, 4'h0, 0, 0);
        do_read(32'h0f000010, 0);

        do_write(32'h0f000ffc, 32'hcafef00d, 4'hf, 0, 0);
        do_read(32'h0f000ffc, 0);
        do_read(32'h0f001000, 0);
        do_write(32'h0efffffc, 32'h12345678, 4'hf, 0, 0);
        do_write(32'h0f001000, 32'h12345678, 4'hf, 0, 0);
        do_read(32'h0f000000, 0);
        do_read(32'h0f000ffc, 0);

        do_read(32'h0f000010, 5);
        do_write(32'h0f000030, 32'h0000beef, 4'b0011, 0, 5);
        do_read(32'h0f000030, 0);

        for (int k = 0; k < 8; k++) do_write(BASE + 32'(4 * k), $urandom, 4'hf, 0, 0);
        for (int it = 0; it < 40; it++) begin
            int sel = $urandom_range(0, 9);
            if (sel < 8) a = BASE + 32'(4 * sel) + 32'($urandom_range(0, 3));
            else if (sel == 8) a = 32'h0f001000 + 32'(4 * $urandom_range(0, 3));
            else a = 32'h0efffffc;
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 0);
            else do_read(a, $urandom_range(0, 2));
        end

        do_write(32'h0f000000, 32'h0badf00d, 4'hf, 0, 0);
        do_read(32'h0f000000, 0);
        do_write(32'h0f001004, 32'h0, 4'hf, 0, 0);
        @(negedge clk);
        axiif.awaddr = 32'h0f000000; axiif.wdata = 32'hffffffff; axiif.wstrb = 4'hf;
        axiif.awvalid = 1'b1; axiif.wvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        axiif.awvalid = 1'b0; axiif.wvalid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_quiet_outputs("mid_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet_outputs("hold_rst");
        rst = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); @(negedge clk);
            if (axiif.bvalid) n++;
        end
        chk("no_spurious_b", n, 0);
        chk("rel_awready", 32'(axiif.awready), 1);
        chk("rel_wready", 32'(axiif.wready), 1);
        do_read(32'h0f000000, 0);
        @(negedge clk);
        d = axiif.rdata;
        chk("abandoned_write", d, 32'h0badf00d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
